// File: rtl/wordexp_pkg.sv
// wordexp shared types and elaboration helpers.
// WORDEXP_INRED_EN adds a PRE state that folds inputs below 2q into [0, q).
package wordexp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef WORDEXP_INRED_EN
    , PRE
`endif
  } state_e;

  function automatic int wordexp_lat(input int w, input int l, input int s);
`ifdef WORDEXP_INRED_EN
    return w * l / s + 2;
`else
    return w * l / s + 1;
`endif
  endfunction

  function automatic int wordexp_cntw(input int w, input int l, input int s);
    return $clog2(w * l / s + 1);
  endfunction

endpackage

// File: rtl/wordexp_moddbl.sv
// One combinational modular doubling step: y = 2x mod q.
// x < q is assumed, so 2x always fits in LOGQ+1 bits.
module moddbl #(
  parameter int LOGQ = 60
) (
  input  logic [LOGQ:0] x,
  input  logic [LOGQ:0] q,
  output logic [LOGQ:0] y
);

  logic [LOGQ:0] d;

  assign d = x << 1;
  assign y = (d >= q) ? d - q : d;

endmodule

// File: rtl/wordexp.sv
// Iterative word expansion Z = A * 2^(W*L) mod q, q = qH*2^W + 1.
// WORDEXP_INRED_EN accepts A < 2q via an extra reduction state.
module wordexp
  import wordexp_pkg::*;
#(
  parameter  int LOGQH = 26,
  parameter  int W     = 34,
  parameter  int L     = 1,
  parameter  int S     = 2,
  localparam int LOGQ  = LOGQH + W,
`ifdef WORDEXP_INRED_EN
  localparam int AW    = LOGQ + 1
`else
  localparam int AW    = LOGQ
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  Z
);

  localparam int N  = W * L;
  localparam int NC = N / S;
  localparam int CW = wordexp_cntw(W, L, S);

  if ((N % S) != 0) begin : g_bad_s
    $error("wordexp: S must divide W*L");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [LOGQ:0] x_q, x_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [LOGQ:0] q_full;
  logic [LOGQ:0] chain [S+1];

  assign q_full = {1'b0, qH, {W{1'b0}}}
                + {{LOGQ{1'b0}}, 1'b1};

  assign chain[0] = x_q;

  for (genvar i = 0; i < S; i++) begin : g_dbl
    moddbl #(.LOGQ(LOGQ)) u_dbl (
      .x(chain[i]),
      .q(q_full),
      .y(chain[i+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    x_d         = x_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef WORDEXP_INRED_EN
          x_d     = A;
          state_d = PRE;
`else
          x_d     = {1'b0, A};
          state_d = RUN;
`endif
          count_d    = '0;
          in_ready_d = 1'b0;
        end
      end
`ifdef WORDEXP_INRED_EN
      PRE: begin
        x_d     = (x_q >= q_full) ? x_q - q_full : x_q;
        state_d = RUN;
      end
`endif
      RUN: begin
        x_d     = chain[S];
        count_d = count_q + CW'(1);
        // the final step's result lands together with the DONE entry
        if (count_q == CW'(NC - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      x_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      x_q         <= x_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = x_q[LOGQ-1:0];

endmodule

// File: tb/tb_wordexp.sv
// Bench for wordexp: small q=17 instances (S=1,2,4) and the default size.
// Reference result is (A << N) mod q with wide integer arithmetic.
module tb_wordexp;

`ifdef WORDEXP_INRED_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int AWS = 8 + XTRA;
  localparam int AWB = 60 + XTRA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]     qh_s = 4'd1;
  logic           iv_s [3];
  logic           ir_s [3];
  logic [AWS-1:0] a_s  [3];
  logic           ov_s [3];
  logic           or_s [3];
  logic [7:0]     z_s  [3];

  logic [25:0]    qhb;
  logic           ivb, irb, ovb, orb;
  logic [AWB-1:0] ab;
  logic [59:0]    zb;

  wordexp #(.LOGQH(4), .W(4), .L(1), .S(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .qH(qh_s),
    .in_valid(iv_s[0]), .in_ready(ir_s[0]), .A(a_s[0]),
    .out_valid(ov_s[0]), .out_ready(or_s[0]), .Z(z_s[0])
  );
  wordexp #(.LOGQH(4), .W(4), .L(1), .S(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .qH(qh_s),
    .in_valid(iv_s[1]), .in_ready(ir_s[1]), .A(a_s[1]),
    .out_valid(ov_s[1]), .out_ready(or_s[1]), .Z(z_s[1])
  );
  wordexp #(.LOGQH(4), .W(4), .L(1), .S(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .qH(qh_s),
    .in_valid(iv_s[2]), .in_ready(ir_s[2]), .A(a_s[2]),
    .out_valid(ov_s[2]), .out_ready(or_s[2]), .Z(z_s[2])
  );
  wordexp u_big (
    .clk(clk), .rst_n(rst_n), .qH(qhb),
    .in_valid(ivb), .in_ready(irb), .A(ab),
    .out_valid(ovb), .out_ready(orb), .Z(zb)
  );

  function automatic logic [127:0] ref_z(
    input logic [127:0] a, input logic [127:0] q, input int n);
    return (a << n) % q;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_small(input int k, input logic [AWS-1:0] a,
                           output int lat, output logic [7:0] z);
    iv_s[k] = 1'b1;
    a_s[k]  = a;
    chk("s_in_ready", ir_s[k], 1);
    @(posedge clk); #1;
    iv_s[k] = 1'b0;
    lat = 1;
    while (!ov_s[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    z = z_s[k];
    @(posedge clk); #1;
  endtask

  task automatic run_big(input logic [AWB-1:0] a,
                         output int lat, output logic [59:0] z);
    ivb = 1'b1;
    ab  = a;
    @(posedge clk); #1;
    ivb = 1'b0;
    lat = 1;
    while (!ovb && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    z = zb;
    @(posedge clk); #1;
  endtask

  function automatic logic [AWB-1:0] rand_a(input logic [59:0] q);
    logic [63:0] r;
    r = {$urandom, $urandom};
`ifdef WORDEXP_INRED_EN
    return AWB'(r % {3'b0, q, 1'b0});
`else
    return AWB'(r % {4'b0, q});
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] zs;
    logic [59:0] zl, qb;
    logic [AWS-1:0] sa [];
    int acc [$];
    logic [59:0] expq [$];
    bit pushed;

    for (int k = 0; k < 3; k++) begin
      iv_s[k] = 1'b0; a_s[k] = '0; or_s[k] = 1'b1;
    end
    ivb = 1'b0; ab = '0; orb = 1'b1;
    qhb = 26'($urandom) | 26'd1;
    qb  = {qhb, 34'b0} + 60'd1;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", ir_s[k], 1);
      chk("rst_out_valid", ov_s[k], 0);
      chk("rst_z", z_s[k], 0);
    end
    chk("rst_big_z", zb, 0);
    chk("rst_big_ov", ovb, 0);

    sa = new[8];
    sa[0] = 1; sa[1] = 3; sa[2] = 16; sa[3] = 0;
    for (int i = 4; i < 8; i++) sa[i] = AWS'($urandom_range(16));
    foreach (sa[i]) begin
      run_small(0, sa[i], lat, zs);
      chk("s1_z", zs, ref_z(sa[i], 17, 4));
      chk("s1_lat", lat, 5 + XTRA);
      chk("s1_idle", ir_s[0], 1);
    end

    run_small(1, 5, lat, zs);
    chk("s2_z", zs, 12);
    chk("s2_lat", lat, 3 + XTRA);
    run_small(2, 5, lat, zs);
    chk("s4_z", zs, 12);
    chk("s4_lat", lat, 2 + XTRA);

    or_s[0] = 1'b0;
    iv_s[0] = 1'b1; a_s[0] = 3;
    @(posedge clk); #1;
    iv_s[0] = 1'b0;
    lat = 1;
    while (!ov_s[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_ov", ov_s[0], 1);
      chk("bp_z", z_s[0], 14);
      chk("bp_ir", ir_s[0], 0);
      @(posedge clk); #1;
    end
    or_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_ov_drop", ov_s[0], 0);
    chk("bp_ir_back", ir_s[0], 1);

    iv_s[0] = 1'b1; a_s[0] = 7;
    @(posedge clk); #1;
    iv_s[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ov", ov_s[0], 0);
    chk("abort_z", z_s[0], 0);
    chk("abort_ir", ir_s[0], 1);
    run_small(0, 2, lat, zs);
    chk("abort_next_z", zs, 15);

`ifdef WORDEXP_INRED_EN
    run_small(0, 20, lat, zs);
    chk("inred_z", zs, 14);
    chk("inred_lat", lat, 6);
`endif

    ivb = 1'b1;
    ab  = rand_a(qb);
    for (int c = 0; c < 300 && acc.size() < 4; c++) begin
      pushed = 1'b0;
      if (ovb) begin
        if (expq.size() > 0) chk("tp_z", zb, expq.pop_front());
      end
      if (irb) begin
        acc.push_back(c);
        expq.push_back(60'(ref_z(ab, qb, 34)));
        pushed = 1'b1;
      end
      @(posedge clk); #1;
      if (pushed) ab = rand_a(qb);
    end
    ivb = 1'b0;
    lat = 0;
    while (!ovb && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (expq.size() > 0) chk("tp_last_z", zb, expq.pop_front());
    @(posedge clk); #1;
    chk("tp_count", acc.size(), 4);
    for (int i = 0; i + 1 < acc.size(); i++)
      chk("tp_period", acc[i+1] - acc[i], 19 + XTRA);

    for (int i = 0; i < 1000; i++) begin
      logic [AWB-1:0] a;
      a = rand_a(qb);
      run_big(a, lat, zl);
      chk("big_z", zl, ref_z(a, qb, 34));
      if (i < 8) chk("big_lat", lat, 18 + XTRA);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wordexp.md
Name: wordexp

Overview:
- Iterative word expansion: computes Z = A * 2^(W*L) mod q, with q = qH*2^W + 1.
- Functional inverse of the word-reduction stage, which divides by 2^W mod q. Used to move operands into the Montgomery domain and to undo excess reduction factors.
- Sits in front of the Montgomery multiplier datapath.
- Bit-serial modular doubling under an FSM with valid/ready handshakes on input and output.

Parameters:
- LOGQH, 26, width of qH.
- W, 34, word size; q = {qH, W'b0} + 1.
- L, 1, number of words of expansion; total doublings N = W*L.
- S, 2, doublings unrolled per cycle; must divide W*L (elaboration error otherwise).
- LOGQ, LOGQH+W, derived operand width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- qH  in  LOGQH  modulus high part; must be stable from in_valid&&in_ready until out_valid&&out_ready.
- in_valid  in  1  A is valid.
- in_ready  out  1  block can accept A.
- A  in  LOGQ  operand; precondition A < q.
- out_valid  out  1  Z is valid.
- out_ready  in  1  consumer accepts Z.
- Z  out  LOGQ  result, always < q.

Behaviour:
- q formed internally as {qH, W'b0} + 1. Accumulator X is LOGQ+1 bits wide to hold 2X before correction.
- FSM states IDLE, RUN, DONE. Reset (rst_n=0 at clk edge) forces IDLE, count=0, X=0: in_ready=1, out_valid=0, Z=0.
- IDLE: in_ready=1. On in_valid: X<=A, count<=0, go to RUN.
- RUN: in_ready=0. Each cycle applies S steps of X = 2X; if X >= q then X -= q. Each step compares against q at full LOGQ+1 width. count += S. After the cycle in which count reaches N, go to DONE.
- DONE: out_valid=1, Z=X[LOGQ-1:0]. Z and out_valid held stable while out_ready=0. On out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: acceptance edge to out_valid = N/S + 1 cycles. Throughput: one result per N/S + 2 cycles with out_ready tied high; no overlap of operations.
- in_valid during RUN/DONE is ignored; in_ready=0 there.
- A=0 gives Z=0. A=q-1 gives Z=q-2^(N) mod q.
- count wraps only via reload in IDLE; never exceeds N.
- Reset mid-RUN or mid-DONE aborts immediately: next cycle is IDLE with out_valid=0, Z=0, and the in-flight result is discarded.
- A >= q is a precondition violation: result unspecified, but the FSM must still return to IDLE.

Optional Feature:
- Macro WORDEXP_INRED_EN.
- Defined: adds state PRE between IDLE and RUN. PRE performs one conditional subtract (X >= q ? X-q : X), so A may be any value < 2q. A is widened to LOGQ+1 bits. Latency becomes N/S + 2.
- Undefined: PRE absent, A is LOGQ bits, precondition A < q.

Decomposition:
- Package wordexp_pkg holds:
  - state enum {IDLE, RUN, DONE[, PRE]};
  - function wordexp_lat(W, L, S), returning the latency;
  - function wordexp_cntw(W, L, S), returning the counter width $clog2(W*L/S + 1).
- Sub-module moddbl: one combinational modular-doubling step (inputs X, q; output 2X mod q). It is instantiated S times in a generate chain. No other sub-modules.

Test Plan:
- W=4, LOGQH=4, qH=1 (q=17), L=1, S=1: A=1 -> Z=16. A=3 -> Z=14. A=16 -> Z=1. A=0 -> Z=0. Each out_valid exactly 5 cycles after acceptance.
- Same modulus, S=2: A=5 -> Z=12 at latency 3 cycles. S=4: A=5 -> Z=12 at latency 2 cycles.
- Backpressure: A=3, out_ready=0 for 10 cycles -> Z=14 held, out_valid=1, in_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Reset mid-RUN: A=7 accepted, rst_n=0 on second RUN cycle -> next cycle out_valid=0, Z=0, in_ready=1. A following A=2 then yields Z=15 (32 mod 17).
- Defaults (W=34, LOGQH=26, L=1, S=2) with a random q and 1000 random A < q -> Z matches a reference model of A*2^34 mod q. Back-to-back in_valid gives one result per 19 cycles.
- WORDEXP_INRED_EN defined, q=17, W=4: A=20 -> Z=(3*16) mod 17 = 14, latency 6 cycles (S=1).
